// File: rtl/sr_latch_bank.sv
// Multi-channel set/reset event latches with sticky overrun flags and a
// lowest-first interrupt request whose index is frozen while being served.
module sr_latch_bank #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] EDGE_MASK   = {CHANNELS{1'b1}},
    parameter int                  IDX_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] SET,
    input  logic [CHANNELS-1:0] CLR,
    input  logic [CHANNELS-1:0] MASK,
    input  logic                ACK,
    output logic [CHANNELS-1:0] STATE,
    output logic [CHANNELS-1:0] OVERRUN,
    output logic                IRQ,
    output logic [IDX_W-1:0]    IDX
);

    typedef enum logic {IDLE, SERVE} fsm_t;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] r_sprev;
    logic [CHANNELS-1:0] w_event;
    logic [CHANNELS-1:0] r_state;
    logic [CHANNELS-1:0] r_ovr;
    logic [CHANNELS-1:0] w_state_nxt;
    logic [CHANNELS-1:0] w_ovr_nxt;
    logic [CHANNELS-1:0] w_pend;
    logic [CHANNELS-1:0] w_idx_hot;
    logic [CHANNELS-1:0] w_ack_hit;
    logic                w_pend_idx;
    logic [IDX_W-1:0]    w_low;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic             r_irq;
    logic             w_irq_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = SET;
        end else begin : g_sync
            logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= SET;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // A held level only counts as an event while the flag is clear, so it
    // re-arms the cycle after ACK/CLR and never produces an overrun by itself.
    assign w_event = (EDGE_MASK & w_s & ~r_sprev) | (~EDGE_MASK & w_s & ~r_state);
    assign w_pend  = r_state & ~MASK;

    always_comb begin
        w_idx_hot = '0;
        w_ack_hit = '0;
        w_low     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_idx_hot[c] = (r_idx == IDX_W'(c));
            w_ack_hit[c] = (r_fsm == SERVE) && ACK && w_idx_hot[c];
        end
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_pend[c]) w_low = IDX_W'(c);
        end
    end

    assign w_pend_idx = |(w_pend & w_idx_hot);

    always_comb begin
        w_state_nxt = r_state;
        w_ovr_nxt   = r_ovr;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CLR[c]) begin
                w_state_nxt[c] = 1'b0;
                w_ovr_nxt[c]   = 1'b0;
            end else if (w_event[c]) begin
                w_state_nxt[c] = 1'b1;
                w_ovr_nxt[c]   = r_ovr[c] | r_state[c];
            end else if (w_ack_hit[c]) begin
                w_state_nxt[c] = 1'b0;
                w_ovr_nxt[c]   = 1'b0;
            end
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_irq_nxt = r_irq;
        w_idx_nxt = r_idx;
        case (r_fsm)
            IDLE: begin
                if (|w_pend) begin
                    w_fsm_nxt = SERVE;
                    w_irq_nxt = 1'b1;
                    w_idx_nxt = w_low;
                end
            end
            SERVE: begin
                if (ACK || !w_pend_idx) begin
                    w_fsm_nxt = IDLE;
                    w_irq_nxt = 1'b0;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
                w_irq_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sprev <= '0;
            r_state <= '0;
            r_ovr   <= '0;
            r_fsm   <= IDLE;
            r_irq   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_sprev <= w_s;
            r_state <= w_state_nxt;
            r_ovr   <= w_ovr_nxt;
            r_fsm   <= w_fsm_nxt;
            r_irq   <= w_irq_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign STATE   = r_state;
    assign OVERRUN = r_ovr;
    assign IRQ     = r_irq;
    assign IDX     = r_idx;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_sr_latch_bank;

    localparam int CH = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [CH-1:0] SET;
    logic [CH-1:0] CLR;
    logic [CH-1:0] MASK;
    logic          ACK;
    logic [CH-1:0] STATE;
    logic [CH-1:0] OVERRUN;
    logic          IRQ;
    logic [2:0]    IDX;

    sr_latch_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .EDGE_MASK  (8'hBF)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .SET    (SET),
        .CLR    (CLR),
        .MASK   (MASK),
        .ACK    (ACK),
        .STATE  (STATE),
        .OVERRUN(OVERRUN),
        .IRQ    (IRQ),
        .IDX    (IDX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          tcyc;
        logic [7:0]  st;
        logic [7:0]  ov;
        logic        irq;
        logic [2:0]  idx;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].tcyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if ({STATE, OVERRUN, IRQ, IDX} !== {e.st, e.ov, e.irq, e.idx}) begin
                n_err++;
                $display("FAIL %s: got state=%h ovr=%h irq=%b idx=%0d, want state=%h ovr=%h irq=%b idx=%0d",
                         e.name, STATE, OVERRUN, IRQ, IDX, e.st, e.ov, e.irq, e.idx);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void chk(input string name, input logic [7:0] st,
                                input logic [7:0] ov, input logic irq,
                                input logic [2:0] idx);
        exp_t x;
        x.name = name;
        x.tcyc = cyc;
        x.st   = st;
        x.ov   = ov;
        x.irq  = irq;
        x.idx  = idx;
        q.push_back(x);
    endfunction

    task automatic pulse(input int ch);
        SET[ch] = 1'b1;
        tick();
        SET[ch] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; SET = '0; CLR = '0; MASK = '0; ACK = 1'b0;
        tick(); tick();
        chk("reset", 8'h00, 8'h00, 1'b0, 3'd0);
        RESET = 1'b0;

        // T1: edge set on ch3, latency and ACK
        SET[3] = 1'b1;
        tick(); chk("t1_sync0", 8'h00, 8'h00, 1'b0, 3'd0);
        tick(); chk("t1_sync1", 8'h00, 8'h00, 1'b0, 3'd0);
        tick(); chk("t1_state", 8'h08, 8'h00, 1'b0, 3'd0);
        tick(); chk("t1_irq",   8'h08, 8'h00, 1'b1, 3'd3);
        tick(); chk("t1_hold",  8'h08, 8'h00, 1'b1, 3'd3);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t1_ack", 8'h00, 8'h00, 1'b0, 3'd3);
        SET[3] = 1'b0; tick(); tick(); tick();
        chk("t1_idle", 8'h00, 8'h00, 1'b0, 3'd3);

        // T2: frozen index, then lower channel served after a low cycle
        SET[5] = 1'b1; tick(); tick(); tick();
        chk("t2_st5", 8'h20, 8'h00, 1'b0, 3'd3);
        tick(); chk("t2_irq5", 8'h20, 8'h00, 1'b1, 3'd5);
        SET[1] = 1'b1; tick(); tick(); tick();
        chk("t2_freeze", 8'h22, 8'h00, 1'b1, 3'd5);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t2_ack5", 8'h02, 8'h00, 1'b0, 3'd5);
        tick(); chk("t2_irq1", 8'h02, 8'h00, 1'b1, 3'd1);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t2_ack1", 8'h00, 8'h00, 1'b0, 3'd1);
        SET[5] = 1'b0; SET[1] = 1'b0; tick(); tick(); tick();

        // T3: CLR beats event; event beats ACK with overrun
        SET[2] = 1'b1; tick(); tick();
        CLR[2] = 1'b1; tick(); CLR[2] = 1'b0;
        chk("t3_clr_wins", 8'h00, 8'h00, 1'b0, 3'd1);
        tick(); chk("t3_clr_drop", 8'h00, 8'h00, 1'b0, 3'd1);
        SET[2] = 1'b0; tick(); tick(); tick();
        SET[2] = 1'b1; tick(); tick(); tick();
        chk("t3_st2", 8'h04, 8'h00, 1'b0, 3'd1);
        tick(); chk("t3_irq2", 8'h04, 8'h00, 1'b1, 3'd2);
        SET[2] = 1'b0; tick(); tick(); tick();
        SET[2] = 1'b1; tick(); tick();
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t3_ev_ack", 8'h04, 8'h04, 1'b0, 3'd2);
        tick(); chk("t3_rearm", 8'h04, 8'h04, 1'b1, 3'd2);
        CLR[2] = 1'b1; tick(); CLR[2] = 1'b0;
        chk("t3_clr", 8'h00, 8'h00, 1'b1, 3'd2);
        tick(); chk("t3_drop", 8'h00, 8'h00, 1'b0, 3'd2);
        SET[2] = 1'b0; tick(); tick(); tick();

        // T4: overrun from two pulses, cleared by CLR
        pulse(0); chk("t4_first",   8'h01, 8'h00, 1'b1, 3'd0);
        pulse(0); chk("t4_overrun", 8'h01, 8'h01, 1'b1, 3'd0);
        CLR[0] = 1'b1; tick(); CLR[0] = 1'b0;
        chk("t4_clr", 8'h00, 8'h00, 1'b1, 3'd0);
        tick(); chk("t4_idle", 8'h00, 8'h00, 1'b0, 3'd0);

        // T5: masking a served channel drops IRQ but keeps the flag
        pulse(4); chk("t5_irq4", 8'h10, 8'h00, 1'b1, 3'd4);
        MASK[4] = 1'b1; tick();
        chk("t5_masked", 8'h10, 8'h00, 1'b0, 3'd4);
        tick(); chk("t5_stay", 8'h10, 8'h00, 1'b0, 3'd4);
        MASK[4] = 1'b0; tick();
        chk("t5_unmask", 8'h10, 8'h00, 1'b1, 3'd4);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t5_ack", 8'h00, 8'h00, 1'b0, 3'd4);

        // T6: level channel re-sets after ACK; reset mid-serve
        SET[6] = 1'b1; tick(); tick(); tick();
        chk("t6_st6", 8'h40, 8'h00, 1'b0, 3'd4);
        tick(); chk("t6_irq6", 8'h40, 8'h00, 1'b1, 3'd6);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("t6_ack", 8'h00, 8'h00, 1'b0, 3'd6);
        tick(); chk("t6_level_reset", 8'h40, 8'h00, 1'b0, 3'd6);
        tick(); chk("t6_irq_again",   8'h40, 8'h00, 1'b1, 3'd6);
        RESET = 1'b1; ACK = 1'b1; tick(); RESET = 1'b0; ACK = 1'b0;
        chk("t6_reset", 8'h00, 8'h00, 1'b0, 3'd0);
        tick(); tick(); tick();
        chk("t6_post_rst_st", 8'h40, 8'h00, 1'b0, 3'd0);
        tick(); chk("t6_post_rst_irq", 8'h40, 8'h00, 1'b1, 3'd6);
        SET[6] = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
